// File: rtl/quanet_regs_pkg.sv
// Shared AXI-Lite response codes, handshake state types and byte-lane helper
// for the QuaNet register bank.
package quanet_regs_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
   typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

   // Expand per-byte strobes into a per-bit enable mask.
   function automatic logic [DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/quanet_regbank_bytewr.sv
// One register of the bank: byte-lane writes, self-clearing pulse bits,
// sticky W1C event bits and the assembled read word.
module quanet_regbank_bytewr
   import quanet_regs_pkg::*;
#(
   parameter logic [DATA_W-1:0] RST_VAL     = '0,
   parameter logic [DATA_W-1:0] RO_MASK     = '0,
   parameter logic [DATA_W-1:0] PULSE_MASK  = '0,
   parameter logic [DATA_W-1:0] STICKY_MASK = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [STRB_W-1:0] i_wstrb,
   input  logic [DATA_W-1:0] i_hw_set,
   input  logic [DATA_W-1:0] i_regs_r,
   output logic [DATA_W-1:0] o_regs_w,
   output logic [DATA_W-1:0] o_rword
);

   localparam logic [DATA_W-1:0] WR_MASK = ~(RO_MASK | STICKY_MASK);

   logic [DATA_W-1:0] r_ctl;
   logic [DATA_W-1:0] r_sticky;
   logic [DATA_W-1:0] w_bmask;
   logic [DATA_W-1:0] w_wmask;
   logic [DATA_W-1:0] w_clr;
   logic [DATA_W-1:0] w_base;

   assign w_bmask = byte_mask(i_wstrb);
   assign w_wmask = i_wr_en ? (w_bmask & WR_MASK) : '0;
   assign w_clr   = i_wr_en ? (w_bmask & i_wdata & STICKY_MASK) : '0;
   // Pulse bits fall back to their reset value unless rewritten this cycle.
   assign w_base  = (r_ctl & ~PULSE_MASK) | (RST_VAL & PULSE_MASK);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctl    <= RST_VAL;
         r_sticky <= '0;
      end else begin
         r_ctl    <= (w_base & ~w_wmask) | (i_wdata & w_wmask);
         // A same-cycle hw event overrides the write-1-to-clear.
         r_sticky <= ((r_sticky & ~w_clr) | i_hw_set) & STICKY_MASK;
      end
   end

   assign o_regs_w = r_ctl;
   assign o_rword  = (i_regs_r & RO_MASK) | (r_sticky & STICKY_MASK) | (r_ctl & WR_MASK);

endmodule

// File: rtl/quanet_regbank.sv
// Parametrised AXI4-Lite register bank between the PS interconnect and QuaNet
// fabric: independent write/read handshake FSMs over per-register update cells.
module quanet_regbank
   import quanet_regs_pkg::*;
#(
   parameter int unsigned             ADDR_W      = 4,
   parameter int unsigned             NUM_REGS    = 16,
   parameter logic [32*NUM_REGS-1:0]  RST_VAL     = '0,
   parameter logic [32*NUM_REGS-1:0]  RO_MASK     = '0,
   parameter logic [32*NUM_REGS-1:0]  PULSE_MASK  = '0,
   parameter logic [32*NUM_REGS-1:0]  STICKY_MASK = '0
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_areset,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [15:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [1:0]               s_axi_bresp,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   input  logic [15:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [1:0]               s_axi_rresp,
   output logic [31:0]              s_axi_rdata,
   output logic [32*NUM_REGS-1:0]   regs_w,
   input  logic [32*NUM_REGS-1:0]   regs_r,
   input  logic [32*NUM_REGS-1:0]   hw_set,
   output logic [NUM_REGS-1:0]      wr_stb
);

   localparam int unsigned BA_W  = ADDR_W + 2;
   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam int unsigned NSLOT = 2 ** ADDR_W;

   if (NUM_REGS < 1 || NUM_REGS > NSLOT) begin : g_num_err
      $error("quanet_regbank: NUM_REGS out of range for ADDR_W");
   end
   if (((PULSE_MASK & STICKY_MASK) != '0) ||
       ((RO_MASK & (PULSE_MASK | STICKY_MASK)) != '0)) begin : g_mask_err
      $error("quanet_regbank: overlapping RO/PULSE/STICKY masks");
   end

   wr_state_t           r_wr_state;
   rd_state_t           r_rd_state;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic [NUM_REGS-1:0] r_wr_stb;
   logic                r_rvalid;
   logic [1:0]          r_rresp;
   logic [31:0]         r_rdata;

   logic [ADDR_W-1:0]   w_aw_idx;
   logic [ADDR_W-1:0]   w_ar_idx;
   logic                w_aw_ok;
   logic                w_ar_ok;
   logic                w_wr_hs;
   logic                w_rd_hs;
   logic [NUM_REGS-1:0] w_wr_sel;
   logic [31:0]         w_rword [NSLOT];
   logic                w_unused;

   assign w_aw_idx = s_axi_awaddr[BA_W-1:2];
   assign w_ar_idx = s_axi_araddr[BA_W-1:2];
   assign w_aw_ok  = ((s_axi_awaddr >> BA_W) == 16'd0) && ({1'b0, w_aw_idx} < IDX_W'(NUM_REGS));
   assign w_ar_ok  = ((s_axi_araddr >> BA_W) == 16'd0) && ({1'b0, w_ar_idx} < IDX_W'(NUM_REGS));
   assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Ready is offered only in the accepting cycle, so it tracks valid directly.
   assign w_wr_hs = s_axi_awvalid && s_axi_wvalid && (r_wr_state == WR_IDLE) && !s_axi_areset;
   assign w_rd_hs = s_axi_arvalid && (r_rd_state == RD_IDLE) && !s_axi_areset;

   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign w_wr_sel[gi] = w_wr_hs && w_aw_ok && (w_aw_idx == ADDR_W'(gi));
      quanet_regbank_bytewr #(
         .RST_VAL     (RST_VAL    [32*gi +: 32]),
         .RO_MASK     (RO_MASK    [32*gi +: 32]),
         .PULSE_MASK  (PULSE_MASK [32*gi +: 32]),
         .STICKY_MASK (STICKY_MASK[32*gi +: 32])
      ) u_bytewr (
         .i_clk    (s_axi_aclk),
         .i_rst    (s_axi_areset),
         .i_wr_en  (w_wr_sel[gi]),
         .i_wdata  (s_axi_wdata),
         .i_wstrb  (s_axi_wstrb),
         .i_hw_set (hw_set[32*gi +: 32]),
         .i_regs_r (regs_r[32*gi +: 32]),
         .o_regs_w (regs_w[32*gi +: 32]),
         .o_rword  (w_rword[gi])
      );
   end
   for (gi = NUM_REGS; gi < NSLOT; gi++) begin : g_pad
      assign w_rword[gi] = '0;
   end

   // Write channel: accept AW+W together, then hold B until bready.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_wr_state <= WR_IDLE;
         r_bvalid   <= 1'b0;
         r_bresp    <= AXI_RESP_OKAY;
         r_wr_stb   <= '0;
      end else begin
         r_wr_stb <= '0;
         case (r_wr_state)
            WR_IDLE: if (w_wr_hs) begin
               r_wr_state <= WR_RESP;
               r_bvalid   <= 1'b1;
               r_bresp    <= w_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
               r_wr_stb   <= w_wr_sel;
            end
            WR_RESP: if (s_axi_bready) begin
               r_wr_state <= WR_IDLE;
               r_bvalid   <= 1'b0;
            end
            default: r_wr_state <= WR_IDLE;
         endcase
      end
   end

   // Read channel: capture the word at AR handshake, hold R until rready.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_rd_state <= RD_IDLE;
         r_rvalid   <= 1'b0;
         r_rresp    <= AXI_RESP_OKAY;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            RD_IDLE: if (w_rd_hs) begin
               r_rd_state <= RD_DATA;
               r_rvalid   <= 1'b1;
               r_rresp    <= w_ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
               r_rdata    <= w_ar_ok ? w_rword[w_ar_idx] : 32'd0;
            end
            RD_DATA: if (s_axi_rready) begin
               r_rd_state <= RD_IDLE;
               r_rvalid   <= 1'b0;
            end
            default: r_rd_state <= RD_IDLE;
         endcase
      end
   end

   assign s_axi_awready = w_wr_hs;
   assign s_axi_wready  = w_wr_hs;
   assign s_axi_arready = w_rd_hs;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign wr_stb        = r_wr_stb;

endmodule

// File: tb/tb_quanet_regbank.sv
// Randomised AXI-Lite bench for quanet_regbank against a per-bit register model.
module tb_quanet_regbank;

   localparam int NR = 12;
   localparam int W  = NR * 32;

   function automatic logic [W-1:0] put(input int idx, input logic [31:0] v);
      logic [W-1:0] r;
      r = '0;
      r[idx*32 +: 32] = v;
      return r;
   endfunction

   localparam logic [W-1:0] P_RST    = put(0, 32'h1234_0000) | put(2, 32'h0000_00A5) |
                                       put(3, 32'h0000_0100) | put(7, 32'hCAFE_0001);
   localparam logic [W-1:0] P_RO     = put(7, 32'hFFFF_0000);
   localparam logic [W-1:0] P_PULSE  = put(3, 32'h0000_0101);
   localparam logic [W-1:0] P_STICKY = put(5, 32'h0000_00F0) | put(8, 32'h8000_0001);

   logic          clk = 1'b0;
   logic          areset;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [15:0]   awaddr, araddr;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [W-1:0]  regs_w, regs_r, hw_set;
   logic [NR-1:0] wr_stb;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_ctl [NR];
   logic [31:0] m_st  [NR];
   logic [31:0] m_rst [NR];
   logic [31:0] m_ro  [NR];
   logic [31:0] m_pu  [NR];
   logic [31:0] m_stm [NR];

   always #5 clk = ~clk;

   quanet_regbank #(
      .ADDR_W(4), .NUM_REGS(NR), .RST_VAL(P_RST), .RO_MASK(P_RO),
      .PULSE_MASK(P_PULSE), .STICKY_MASK(P_STICKY)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(areset),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
      .s_axi_awprot(3'b000),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
      .s_axi_arprot(3'b000),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rresp(rresp), .s_axi_rdata(rdata),
      .regs_w(regs_w), .regs_r(regs_r), .hw_set(hw_set), .wr_stb(wr_stb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic in_range(input logic [15:0] a);
      return (a[15:6] == 10'd0) && (int'(a[5:2]) < NR);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [15:0] a);
      return in_range(a) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] m_read(input logic [15:0] a);
      logic [31:0] v;
      int idx;
      v = '0;
      if (!in_range(a)) return v;
      idx = int'(a[5:2]);
      for (int b = 0; b < 32; b++) begin
         if (m_ro[idx][b])       v[b] = regs_r[idx*32 + b];
         else if (m_stm[idx][b]) v[b] = m_st[idx][b];
         else                    v[b] = m_ctl[idx][b];
      end
      return v;
   endfunction

   task automatic m_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (!in_range(a)) return;
      idx = int'(a[5:2]);
      for (int b = 0; b < 32; b++) begin
         if (s[b/8] && !m_ro[idx][b]) begin
            if (m_stm[idx][b]) begin
               if (d[b]) m_st[idx][b] = 1'b0;
            end else begin
               m_ctl[idx][b] = d[b];
            end
         end
      end
   endtask

   task automatic m_hw(input logic [W-1:0] hs);
      for (int i = 0; i < NR; i++) m_st[i] = m_st[i] | (hs[i*32 +: 32] & m_stm[i]);
   endtask

   task automatic m_expire_pulses();
      for (int i = 0; i < NR; i++) m_ctl[i] = (m_ctl[i] & ~m_pu[i]) | (m_rst[i] & m_pu[i]);
   endtask

   task automatic m_reset();
      for (int i = 0; i < NR; i++) begin
         m_ctl[i] = m_rst[i];
         m_st[i]  = '0;
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++)
         chk($sformatf("%s_regs_w%0d", tag, i), regs_w[i*32 +: 32], m_ctl[i]);
   endtask

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] r;
      for (int i = 0; i < NR; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- bus tasks ----------------
   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [W-1:0] hs);
      logic ok;
      logic [31:0] exp_stb;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; hw_set = hs;
      ok = 1'b0;
      for (int n = 0; n < 16; n++) begin
         #1;
         if (awready && wready) begin ok = 1'b1; break; end
         tick();
      end
      tick();
      awvalid = 1'b0; wvalid = 1'b0; hw_set = '0;
      if (!ok) begin
         chk("wr_handshake_timeout", 32'd0, 32'd1);
         return;
      end
      m_write(a, d, s);
      m_hw(hs);
      exp_stb = in_range(a) ? (32'd1 << a[5:2]) : 32'd0;
      chk("bvalid_rise", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'(exp_resp(a)));
      chk("wr_stb_pulse", 32'(wr_stb), exp_stb);
      check_regs("wr_t1");
      m_expire_pulses();
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_fall", 32'(bvalid), 32'd0);
      chk("wr_stb_clear", 32'(wr_stb), 32'd0);
      check_regs("wr_t2");
   endtask

   task automatic axi_read(input logic [15:0] a);
      logic ok;
      logic [31:0] exp;
      araddr = a; arvalid = 1'b1;
      ok = 1'b0;
      exp = '0;
      for (int n = 0; n < 16; n++) begin
         #1;
         if (arready) begin ok = 1'b1; exp = m_read(a); break; end
         tick();
      end
      tick();
      arvalid = 1'b0;
      if (!ok) begin
         chk("rd_handshake_timeout", 32'd0, 32'd1);
         return;
      end
      chk("rvalid_rise", 32'(rvalid), 32'd1);
      chk($sformatf("rdata@%h", a), rdata, exp);
      chk("rresp", 32'(rresp), 32'(exp_resp(a)));
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_fall", 32'(rvalid), 32'd0);
   endtask

   // Write and read issued in the same cycle: the read sees the old value.
   task automatic axi_rw_same(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] exp;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      araddr = a; arvalid = 1'b1;
      #1;
      chk("rw_awready", 32'(awready), 32'd1);
      chk("rw_arready", 32'(arready), 32'd1);
      exp = m_read(a);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      m_write(a, d, s);
      chk("rw_rdata_prewrite", rdata, exp);
      chk("rw_bvalid", 32'(bvalid), 32'd1);
      chk("rw_rvalid", 32'(rvalid), 32'd1);
      check_regs("rw");
      m_expire_pulses();
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
   endtask

   task automatic hw_event(input logic [W-1:0] hs);
      hw_set = hs;
      tick();
      hw_set = '0;
      m_hw(hs);
   endtask

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      a = {10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a[$urandom_range(6, 15)] = 1'b1;
      return a;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] held;
      for (int i = 0; i < NR; i++) begin
         m_rst[i] = P_RST[i*32 +: 32];
         m_ro[i]  = P_RO[i*32 +: 32];
         m_pu[i]  = P_PULSE[i*32 +: 32];
         m_stm[i] = P_STICKY[i*32 +: 32];
      end
      m_reset();
      regs_r = rand_wide();
      hw_set = '0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      bready = 1'b0; rready = 1'b0;
      // Valids high during reset must not be accepted.
      areset = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      areset = 1'b0;
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_reg2_const", regs_w[95:64], 32'h0000_00A5);
      check_regs("rst");
      tick();

      axi_read(16'h0008);
      axi_write(16'h0004, 32'hDEAD_BEEF, 4'b0101, '0);
      chk("strb_reg1_const", regs_w[63:32], 32'h00AD_00EF);

      // Pulse bit: bit0 pulses high one cycle, bit8 dips to 0 and returns to 1.
      axi_write(16'h000C, 32'h0000_0001, 4'hF, '0);
      axi_read(16'h000C);
      chk("pulse_reg3_const", regs_w[127:96], 32'h0000_0100);

      // Sticky bit set, W1C losing to simultaneous hw_set, then a clean clear.
      hw_event(put(5, 32'h0000_0010));
      axi_read(16'h0014);
      axi_write(16'h0014, 32'h0000_0010, 4'hF, put(5, 32'h0000_0010));
      axi_read(16'h0014);
      axi_write(16'h0014, 32'h0000_0010, 4'hF, '0);
      axi_read(16'h0014);

      // Out-of-range accesses.
      axi_write(16'h0030, 32'hFFFF_FFFF, 4'hF, '0);
      axi_read(16'h0040);
      axi_write(16'h1004, 32'h5555_5555, 4'hF, '0);
      axi_read(16'h2008);

      // Read-only upper half of reg7.
      axi_write(16'h001C, 32'hFFFF_FFFF, 4'hF, '0);
      axi_read(16'h001C);
      axi_rw_same(16'h0004, 32'h1357_9BDF, 4'hF);

      // Stalled B and R channels, then reset while both are pending.
      awaddr = 16'h0004; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      chk("stall_aw_hs", 32'(awready), 32'd1);
      tick();
      m_write(16'h0004, 32'h1111_2222, 4'hF);
      awaddr = 16'h0008;
      araddr = 16'h0004; arvalid = 1'b1;
      #1;
      chk("stall_ar_hs", 32'(arready), 32'd1);
      held = m_read(16'h0004);
      tick();
      arvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_bvalid", 32'(bvalid), 32'd1);
         chk("stall_awready", 32'(awready), 32'd0);
         chk("stall_rvalid", 32'(rvalid), 32'd1);
         chk("stall_rdata", rdata, held);
         tick();
      end
      areset = 1'b1;
      #1;
      chk("midrst_awready", 32'(awready), 32'd0);
      tick();
      areset = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      m_reset();
      chk("midrst_bvalid", 32'(bvalid), 32'd0);
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      check_regs("midrst");
      tick();

      // Randomised traffic.
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 8))
            0, 1, 2, 3: axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                                  ($urandom_range(0, 2) == 0) ? (rand_wide() & P_STICKY) : '0);
            4, 5:       axi_read(rand_addr());
            6:          hw_event(rand_wide() & rand_wide() & P_STICKY);
            7:          begin regs_r = rand_wide(); tick(); end
            default:    axi_rw_same({10'd0, 4'($urandom_range(0, NR - 1)), 2'b00}, $urandom,
                                    4'($urandom_range(0, 15)));
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/quanet_regbank.md
# quanet_regbank

Parametrised AXI4-Lite register bank; the next-generation control/status block between the PS AXI interconnect and QuaNet fabric logic. It generalises the register file to any register count and adds:
- byte-lane write strobes;
- self-clearing pulse bits;
- sticky write-1-to-clear event bits;
- per-register write strobes;
- SLVERR on out-of-range accesses.

It implements its own AXI-Lite handshake directly, single clock domain, with no separate up_* bus.

## Interface
Parameters:
- ADDR_W, 4: register index bits; byte address bits used = ADDR_W+2.
- NUM_REGS, 16: implemented registers, 1..2**ADDR_W.
- RST_VAL, 0: 32*NUM_REGS-bit reset image of regs_w.
- RO_MASK, 0: 32*NUM_REGS; 1 = bit reads regs_r and ignores writes.
- PULSE_MASK, 0: 32*NUM_REGS; 1 = writable bit self-clears one cycle after being written.
- STICKY_MASK, 0: 32*NUM_REGS; 1 = bit is a sticky event bit, set by hw_set, cleared by writing 1.

Ports:
- s_axi_aclk, in, 1: sole clock.
- s_axi_areset, in, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- s_axi_awvalid/awready, in/out, 1: write address handshake.
- s_axi_awaddr, in, 16: byte address.
- s_axi_awprot, in, 3: ignored.
- s_axi_wvalid/wready, in/out, 1: write data handshake.
- s_axi_wdata, in, 32.
- s_axi_wstrb, in, 4: byte enables.
- s_axi_bvalid/bready, out/in, 1.
- s_axi_bresp, out, 2.
- s_axi_arvalid/arready, in/out, 1.
- s_axi_araddr, in, 16.
- s_axi_arprot, in, 3: ignored.
- s_axi_rvalid/rready, out/in, 1.
- s_axi_rresp, out, 2.
- s_axi_rdata, out, 32.
- regs_w, out, 32*NUM_REGS: control register image.
- regs_r, in, 32*NUM_REGS: hardware read-only status; only RO_MASK bits are used.
- hw_set, in, 32*NUM_REGS: one-cycle event inputs for STICKY_MASK bits.
- wr_stb, out, NUM_REGS: one-cycle pulse when register i accepts a write.

## Operation
Address decode:
- Register index = addr[ADDR_W+1:2]; addr[1:0] ignored.
- Out of range if addr[15:ADDR_W+2] ≠ 0 or index ≥ NUM_REGS.

Writes:
- The write is taken when awvalid and wvalid are both high and no B response is pending; awready and wready are asserted together in that cycle.
- For each byte lane with wstrb set, and each bit not in RO_MASK:
  - bits in neither PULSE_MASK nor STICKY_MASK take wdata;
  - PULSE_MASK bits take wdata and return to RST_VAL the next cycle;
  - STICKY_MASK bits clear where wdata=1.
- Out-of-range writes change nothing, assert no wr_stb and respond SLVERR (2'b10); otherwise the response is OKAY (2'b00).

Sticky bits:
- Set on hw_set=1 in any cycle.
- hw_set wins over a simultaneous write-1-to-clear.

Reads:
- Handshake when arvalid and no R is pending.
- Read word per bit: RO_MASK bit → regs_r; STICKY_MASK bit → sticky state; otherwise → regs_w.
- Out-of-range reads return rdata=0 with SLVERR.
- Reads and writes proceed independently; a read of a register written in the same cycle returns the pre-write value.

Overlaps: PULSE_MASK ∩ STICKY_MASK and RO_MASK ∩ (PULSE_MASK | STICKY_MASK) must be zero; the block flags a violation with an elaboration-time check.

## Timing
- Reset values: regs_w=RST_VAL, sticky bits=0, wr_stb=0, bvalid=0, rvalid=0, rdata=0, bresp=rresp=0, all ready=0 in the reset cycle.
- Write: in handshake cycle T, regs_w updates and wr_stb pulses at T+1, and bvalid rises at T+1, held until bready. The next write handshake is no earlier than the cycle after bvalid&bready.
- Pulse bits: high exactly one cycle, at T+1.
- Read: for handshake at T, rvalid and rdata are valid at T+1 and held stable until rready. Throughput is one read per 2 cycles with rready tied high.
- hw_set at cycle T is visible in reads handshaken at T+1 or later.
- Reset asserted mid-transaction: pending B/R responses are dropped, all state returns to reset values the next cycle, and no partial write occurs.

## Structure
- Shared package quanet_regs_pkg: AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
- One sub-module, quanet_regbank_bytewr: per-register byte/pulse/sticky update logic, instantiated NUM_REGS times from a generate loop.
- Handshake FSMs stay in the top level:
  - write FSM: IDLE→RESP (on AW&W handshake), RESP→IDLE (on bready);
  - read FSM: IDLE→DATA (on AR handshake), DATA→IDLE (on rready).

## Test plan
- Reset with RST_VAL reg2=0x0000_00A5 → regs_w reg2=0xA5; a read of addr 0x08 returns 0xA5, OKAY.
- Write 0xDEADBEEF to addr 0x04, wstrb=4'b0101 (prior value 0) → reg1=0x00AD00EF, wr_stb[1] one cycle, bresp=OKAY.
- PULSE_MASK reg3 bit0: write 0x1 → regs_w[96] high exactly one cycle, then 0; readback 0.
- STICKY_MASK reg5 bit4: hw_set pulse → read 0x10. Then write-1 to bit4 in the same cycle as another hw_set → bit stays 1. A later write 0x10 → reads 0.
- With NUM_REGS=12: write addr 0x30 and read addr 0x40 → SLVERR, rdata 0, regs_w unchanged, no wr_stb.
- Hold bready/rready low 5 cycles → bvalid/rvalid and rdata stable, awready stays 0. Assert reset mid-hold → bvalid/rvalid 0 the next cycle.
